// File: rtl/lsu_mem_if.sv
// Data-bus bundle between the load/store unit and the data memory.
// Signal names keep the unit-side direction suffixes so the bus reads the
// same from either end.
interface lsu_mem_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  // Load/store unit side: drives the request, receives the response.
  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );

  // Memory side: receives the request, drives the response.
  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/lsu_mem.sv
// Memory stage load/store unit: issues one big-endian bus access per memory
// op, stalls the pipeline until it completes, aborts after BUS_TIMEOUT
// unacknowledged cycles and reports misaligned accesses without touching
// the bus.
module lsu_mem #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  lsu_mem_if.master   bus
);

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Counter only has to reach BUS_TIMEOUT-1: the last WAIT cycle is the one
  // in which the count equals that value and no ack arrives.
  localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx;
  logic [CW-1:0] cnt_r;
  logic [31:0]   rdata_r;
  logic          err_r;
  logic          mis_r;

  logic          is_load_s;
  logic          is_store_s;
  logic          is_mem_s;
  logic          sext_s;
  logic [1:0]    size_s;
  logic          misalign_s;
  logic [3:0]    sel_s;
  logic [31:0]   st_data_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   load_data_s;
  logic          timeout_s;

  // Decode the execute-stage op into load/store, access size and signedness.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    sext_s     = 1'b0;
    size_s     = SZ_W;
    case (aluop_i)
      OP_LB:   begin is_load_s  = 1'b1; size_s = SZ_B; sext_s = 1'b1; end
      OP_LBU:  begin is_load_s  = 1'b1; size_s = SZ_B; end
      OP_LH:   begin is_load_s  = 1'b1; size_s = SZ_H; sext_s = 1'b1; end
      OP_LHU:  begin is_load_s  = 1'b1; size_s = SZ_H; end
      OP_LW:   begin is_load_s  = 1'b1; size_s = SZ_W; end
      OP_SB:   begin is_store_s = 1'b1; size_s = SZ_B; end
      OP_SH:   begin is_store_s = 1'b1; size_s = SZ_H; end
      OP_SW:   begin is_store_s = 1'b1; size_s = SZ_W; end
      default: begin is_load_s  = 1'b0; is_store_s = 1'b0; end
    endcase
    is_mem_s   = is_load_s | is_store_s;
    misalign_s = is_mem_s & (((size_s == SZ_H) & mem_addr_i[0]) |
                             ((size_s == SZ_W) & (mem_addr_i[1:0] != 2'b00)));
  end

  // Big-endian byte-lane select and replicated store data for the request.
  always_comb begin
    sel_s     = 4'b1111;
    st_data_s = reg2_i;
    case (size_s)
      SZ_B: begin
        st_data_s = {4{reg2_i[7:0]}};
        case (mem_addr_i[1:0])
          2'b00:   sel_s = 4'b1000;
          2'b01:   sel_s = 4'b0100;
          2'b10:   sel_s = 4'b0010;
          default: sel_s = 4'b0001;
        endcase
      end
      SZ_H: begin
        st_data_s = {2{reg2_i[15:0]}};
        if (mem_addr_i[1]) begin
          sel_s = 4'b0011;
        end else begin
          sel_s = 4'b1100;
        end
      end
      default: begin
        sel_s     = 4'b1111;
        st_data_s = reg2_i;
      end
    endcase
  end

  // Extract and extend the addressed lane from the captured read word.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    load_data_s = rdata_r;
    case (size_s)
      SZ_B: begin
        case (mem_addr_i[1:0])
          2'b00:   byte_s = rdata_r[31:24];
          2'b01:   byte_s = rdata_r[23:16];
          2'b10:   byte_s = rdata_r[15:8];
          default: byte_s = rdata_r[7:0];
        endcase
        load_data_s = sext_s ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
      end
      SZ_H: begin
        if (mem_addr_i[1]) begin
          half_s = rdata_r[15:0];
        end else begin
          half_s = rdata_r[31:16];
        end
        load_data_s = sext_s ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
      end
      default: load_data_s = rdata_r;
    endcase
  end

  // Next-state logic; an ack in the final counted cycle wins over the abort.
  always_comb begin
    state_nx  = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s) begin
          state_nx = misalign_s ? DONE : WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (bus.bus_ack_i) begin
          state_nx = DONE;
        end else if (cnt_r == CNT_LAST) begin
          state_nx  = DONE;
          timeout_s = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, registered bus request, timeout counter and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      cnt_r           <= '0;
      rdata_r         <= 32'h00000000;
      err_r           <= 1'b0;
      mis_r           <= 1'b0;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= 32'h00000000;
      bus.bus_sel_o   <= 4'b0000;
      bus.bus_wdata_o <= 32'h00000000;
    end else begin
      state_r <= state_nx;
      err_r   <= 1'b0;
      mis_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (is_mem_s && !misalign_s) begin
            cnt_r           <= '0;
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= is_store_s;
            bus.bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus.bus_sel_o   <= sel_s;
            bus.bus_wdata_o <= st_data_s;
          end else begin
            mis_r <= is_mem_s & misalign_s;
          end
        end
        WAIT: begin
          if (bus.bus_ack_i) begin
            bus.bus_req_o <= 1'b0;
            if (is_load_s) begin
              rdata_r <= bus.bus_rdata_i;
            end else begin
              rdata_r <= rdata_r;
            end
          end else if (timeout_s) begin
            bus.bus_req_o <= 1'b0;
            err_r         <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          err_r <= 1'b0;
          mis_r <= 1'b0;
        end
        default: begin
          bus.bus_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Write-back and stall outputs: pass-through for non-memory ops, held off
  // while an access is pending, lane data delivered in DONE.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    if (rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = 32'h00000000;
    end else if (is_mem_s) begin
      stallreq_o = (state_r != DONE);
      wreg_o     = 1'b0;
      wdata_o    = 32'h00000000;
      if (state_r == DONE) begin
        misalign_o = mis_r;
        bus_err_o  = err_r;
        if (is_load_s && !mis_r && !err_r) begin
          wreg_o  = wreg_i;
          wdata_o = load_data_s;
        end else begin
          wreg_o  = 1'b0;
          wdata_o = 32'h00000000;
        end
      end else begin
        misalign_o = 1'b0;
      end
    end else begin
      stallreq_o = 1'b0;
    end
  end

endmodule
